// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: round-robin arbiter sharing one WIDTH-bit register among NREQ requesters, with lock
module dff_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            lock,
  input  logic [NREQ*WIDTH-1:0]      wdata,
  output logic [NREQ-1:0]            gnt,
  output logic [$clog2(NREQ)-1:0]    owner,
  output logic [WIDTH-1:0]           q,
  output logic                       q_valid
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic {ARB, LOCKED} state_t;
  state_t            state_q;
  logic [IW-1:0]     ptr_q, owner_q, win_d;
  logic [NREQ-1:0]   gnt_q;
  logic [WIDTH-1:0]  data_q, lane_w, lane_o;
  logic              valid_q;
  // descending scan so the smallest offset from ptr wins
  always_comb begin
    win_d = ptr_q;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[(int'(ptr_q) + k) % NREQ]) win_d = IW'((int'(ptr_q) + k) % NREQ);
  end
  assign lane_w  = wdata[int'(win_d)*WIDTH +: WIDTH];
  assign lane_o  = wdata[int'(owner_q)*WIDTH +: WIDTH];
  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign q       = data_q;
  assign q_valid = valid_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (state_q == ARB) begin
      if (|req) begin
        gnt_q   <= NREQ'(1) << win_d;
        owner_q <= win_d;
        data_q  <= lane_w;
        valid_q <= 1'b1;
        ptr_q   <= (win_d == IW'(NREQ - 1)) ? '0 : win_d + 1'b1;
        state_q <= lock[win_d] ? LOCKED : ARB;
      end else begin
        gnt_q   <= '0;
        valid_q <= 1'b0;
      end
    end else begin
      gnt_q   <= req[owner_q] ? NREQ'(1) << owner_q : '0;
      valid_q <= req[owner_q];
      if (req[owner_q]) data_q <= lane_o;
      state_q <= (req[owner_q] && lock[owner_q]) ? LOCKED : ARB;
    end
  end
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb_dff_bank_arbiter: directed scenario tasks with hand-computed expectations
module tb_dff_bank_arbiter;
  logic        clk, rst;
  logic [3:0]  req, lock, gnt;
  logic [31:0] wdata;
  logic [1:0]  owner;
  logic [7:0]  q;
  logic        q_valid;
  int          ncmp, nerr;

  dff_bank_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .wdata(wdata),
    .gnt(gnt), .owner(owner), .q(q), .q_valid(q_valid)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; req = 0; lock = 0; wdata = 0;
    #3;
    ncmp++; if (gnt !== 4'b0 || q !== 8'h00 || q_valid !== 1'b0 || owner !== 2'd0) begin nerr++; $display("FAIL reset_init gnt=%b q=%h v=%b owner=%0d want 0000/00/0/0", gnt, q, q_valid, owner); end
    step(); step();
    rst = 0;
    req = 4'b0001; lock = 4'b0001; wdata = 32'h0000_0077;
    step();
    ncmp++; if (gnt !== 4'b0001 || q !== 8'h77) begin nerr++; $display("FAIL reset_pre_lock gnt=%b q=%h want 0001/77", gnt, q); end
    #3 rst = 1;
    #1;
    ncmp++; if (gnt !== 4'b0 || q !== 8'h00 || q_valid !== 1'b0 || owner !== 2'd0) begin nerr++; $display("FAIL reset_async gnt=%b q=%h v=%b owner=%0d want 0000/00/0/0", gnt, q, q_valid, owner); end
    #2 rst = 0;
    req = 4'b0011; lock = 0; wdata = 32'h0000_2211;
    step();
    ncmp++; if (gnt !== 4'b0001 || q !== 8'h11 || owner !== 2'd0) begin nerr++; $display("FAIL reset_first_grant gnt=%b q=%h owner=%0d want 0001/11/0", gnt, q, owner); end
    req = 0;
    step();
  endtask

  task automatic test_single();
    req = 4'b0010; wdata = 32'h0000_A500;
    step();
    ncmp++; if (gnt !== 4'b0010 || q !== 8'hA5 || q_valid !== 1'b1 || owner !== 2'd1) begin nerr++; $display("FAIL single_write gnt=%b q=%h v=%b owner=%0d want 0010/A5/1/1", gnt, q, q_valid, owner); end
    req = 0; wdata = 32'hFFFF_FFFF;
    step();
    ncmp++; if (gnt !== 4'b0 || q !== 8'hA5 || q_valid !== 1'b0 || owner !== 2'd1) begin nerr++; $display("FAIL single_idle gnt=%b q=%h v=%b owner=%0d want 0000/A5/0/1", gnt, q, q_valid, owner); end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg [5];
    logic [7:0] eq [5];
    eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    eq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    req = 4'b1000; wdata = 32'h9900_0000;
    step();
    ncmp++; if (gnt !== 4'b1000 || q !== 8'h99) begin nerr++; $display("FAIL rr_setup gnt=%b q=%h want 1000/99", gnt, q); end
    req = 4'b1111; wdata = 32'h4433_2211;
    for (int i = 0; i < 5; i++) begin
      step();
      ncmp++; if (gnt !== eg[i] || q !== eq[i] || q_valid !== 1'b1) begin nerr++; $display("FAIL rr_cycle%0d gnt=%b q=%h v=%b want %b/%h/1", i, gnt, q, q_valid, eg[i], eq[i]); end
    end
    req = 0;
    step();
  endtask

  task automatic test_lock();
    req = 4'b0010; wdata = 32'h0000_0100;
    step();
    req = 4'b0101; lock = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      wdata = {8'h00, 8'h5A + 8'(i), 8'h00, 8'hF0};
      step();
      ncmp++; if (gnt !== 4'b0100 || owner !== 2'd2 || q !== 8'h5A + 8'(i)) begin nerr++; $display("FAIL lock_hold%0d gnt=%b owner=%0d q=%h want 0100/2/%h", i, gnt, owner, q, 8'h5A + 8'(i)); end
    end
    lock = 0; wdata = 32'h005D_00F0;
    step();
    ncmp++; if (gnt !== 4'b0100 || q !== 8'h5D) begin nerr++; $display("FAIL lock_final gnt=%b q=%h want 0100/5D", gnt, q); end
    step();
    ncmp++; if (gnt !== 4'b0001 || q !== 8'hF0 || owner !== 2'd0) begin nerr++; $display("FAIL lock_release gnt=%b q=%h owner=%0d want 0001/F0/0", gnt, q, owner); end
    req = 0;
    step();
  endtask

  task automatic test_lock_req_low();
    req = 4'b0010; lock = 4'b0010; wdata = 32'h0000_C300;
    step();
    ncmp++; if (gnt !== 4'b0010 || q !== 8'hC3) begin nerr++; $display("FAIL lrl_grant gnt=%b q=%h want 0010/C3", gnt, q); end
    req = 4'b1101; wdata = 32'hB4D4_00A1;
    step();
    ncmp++; if (gnt !== 4'b0 || q_valid !== 1'b0 || q !== 8'hC3) begin nerr++; $display("FAIL lrl_drop gnt=%b v=%b q=%h want 0000/0/C3", gnt, q_valid, q); end
    lock = 0;
    step();
    ncmp++; if (gnt !== 4'b0100 || q !== 8'hD4 || owner !== 2'd2) begin nerr++; $display("FAIL lrl_ptr gnt=%b q=%h owner=%0d want 0100/D4/2", gnt, q, owner); end
    req = 0;
    step();
  endtask

  task automatic test_idle_gap();
    req = 0; lock = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step();
      ncmp++; if (gnt !== 4'b0 || q_valid !== 1'b0 || q !== 8'hD4) begin nerr++; $display("FAIL idle%0d gnt=%b v=%b q=%h want 0000/0/D4", i, gnt, q_valid, q); end
    end
    lock = 0; req = 4'b1001; wdata = 32'hE300_00E0;
    step();
    ncmp++; if (gnt !== 4'b1000 || q !== 8'hE3 || owner !== 2'd3) begin nerr++; $display("FAIL idle_w3 gnt=%b q=%h owner=%0d want 1000/E3/3", gnt, q, owner); end
    req = 4'b0001;
    step();
    ncmp++; if (gnt !== 4'b0001 || q !== 8'hE0 || owner !== 2'd0) begin nerr++; $display("FAIL idle_w0 gnt=%b q=%h owner=%0d want 0001/E0/0", gnt, q, owner); end
    req = 0;
    step();
  endtask

  initial begin
    ncmp = 0; nerr = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_lock_req_low();
    test_idle_gap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
